// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: pipeline-side requester for the multiply/divide unit.
// Gates the E-stage MD opcode onto the unit and shadows the unit's latency.
// It stalls HI/LO users in D while an operation is outstanding, checks the
// busy handshake and counts stall cycles.
module md_issue_ctrl #(
  parameter int unsigned MUL_LAT = 5,   // busy cycles after a mult/multu issue edge
  parameter int unsigned DIV_LAT = 10,  // busy cycles after a div/divu issue edge
  parameter int unsigned CNT_W   = 4    // remaining-cycle counter width, must hold DIV_LAT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  MDop_E,
  input  logic        Kill_E,
  input  logic        MDuse_D,
  input  logic        busy,
  output logic [2:0]  MDop_out,
  output logic        Stall_MD,
  output logic [1:0]  md_state,
  output logic [31:0] stall_cnt,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMulWait = 2'd1,
    StDivWait = 2'd2
  } md_state_e;

  localparam logic [2:0] OpMult  = 3'd3;
  localparam logic [2:0] OpMultu = 3'd4;
  localparam logic [2:0] OpDiv   = 3'd5;
  localparam logic [2:0] OpDivu  = 3'd6;

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] RemOne  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             proto_err_q, proto_err_d;
  // High when the previous cycle was the final wait cycle (remain == 1).
  logic             last_wait_q, last_wait_d;

  logic issue;
  logic issue_div;
  logic waiting;
  logic last_wait;
  logic err_wait_idle;
  logic err_idle_busy;
  logic err_issue;

  // Opcode gating, issue decode and the D-stage stall request.
  always_comb begin
    MDop_out  = Kill_E ? 3'd0 : MDop_E;
    issue     = MDop_out inside {OpMult, OpMultu, OpDiv, OpDivu};
    issue_div = (MDop_out == OpDiv) || (MDop_out == OpDivu);
    waiting   = (state_q != StIdle);
    last_wait = waiting && (remain_q == RemOne);
    // Issue itself stalls: busy only rises the cycle after the issue edge.
    Stall_MD  = MDuse_D & (issue | busy | waiting);
  end

  // Latency shadow next state; an issue the unit cannot accept is ignored.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    unique case (state_q)
      StIdle: begin
        if (issue && !busy) begin
          state_d  = issue_div ? StDivWait : StMulWait;
          remain_d = issue_div ? DivLoad : MulLoad;
        end
      end
      StMulWait, StDivWait: begin
        if (remain_q <= RemOne) begin
          state_d  = StIdle;
          remain_d = '0;
        end else begin
          remain_d = remain_q - RemOne;
        end
      end
      default: begin
        state_d  = StIdle;
        remain_d = '0;
      end
    endcase
  end

  // Busy-handshake checks, sticky error flag and stall cycle counter.
  always_comb begin
    err_wait_idle = waiting & ~busy;
    // Busy may linger one cycle into IDLE: that is the unit's HI/LO write edge.
    err_idle_busy = ~waiting & busy & ~last_wait_q;
    err_issue     = issue & (waiting | busy);
    proto_err_d   = proto_err_q | err_wait_idle | err_idle_busy | err_issue;
    stall_cnt_d   = stall_cnt_q + 32'(Stall_MD);
    last_wait_d   = last_wait;
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      remain_q    <= '0;
      stall_cnt_q <= '0;
      proto_err_q <= 1'b0;
      last_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      stall_cnt_q <= stall_cnt_d;
      proto_err_q <= proto_err_d;
      last_wait_q <= last_wait_d;
    end
  end

  assign md_state  = state_q;
  assign stall_cnt = stall_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: directed per-cycle vectors with
// hand-computed expectations, checked by a separate negedge monitor.
module tb_md_issue_ctrl;

  logic        Clk;
  logic        Reset;
  logic [2:0]  MDop_E;
  logic        Kill_E;
  logic        MDuse_D;
  logic        busy;
  logic [2:0]  MDop_out;
  logic        Stall_MD;
  logic [1:0]  md_state;
  logic [31:0] stall_cnt;
  logic        proto_err;

  md_issue_ctrl #(
    .MUL_LAT(5),
    .DIV_LAT(10),
    .CNT_W  (4)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .MDop_E   (MDop_E),
    .Kill_E   (Kill_E),
    .MDuse_D  (MDuse_D),
    .busy     (busy),
    .MDop_out (MDop_out),
    .Stall_MD (Stall_MD),
    .md_state (md_state),
    .stall_cnt(stall_cnt),
    .proto_err(proto_err)
  );

  typedef struct {
    bit          chk;
    int          cyc;
    logic [2:0]  op;
    logic        stall;
    logic [1:0]  state;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc_no   = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Drive one cycle of inputs and queue the values the DUT must show that cycle.
  task automatic cyc(input bit chk, input logic rst, input logic [2:0] op, input logic kill,
                     input logic use_d, input logic bsy, input logic [2:0] e_op,
                     input logic e_stall, input logic [1:0] e_state, input int e_cnt,
                     input logic e_err);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset   = rst;
    MDop_E  = op;
    Kill_E  = kill;
    MDuse_D = use_d;
    busy    = bsy;
    e.chk   = chk;
    e.cyc   = cyc_no;
    e.op    = e_op;
    e.stall = e_stall;
    e.state = e_state;
    e.cnt   = 32'(e_cnt);
    e.err   = e_err;
    exp_q.push_back(e);
    cyc_no++;
  endtask

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle, mid-cycle, and compares all outputs.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        check("MDop_out",  e.cyc, 32'(MDop_out),  32'(e.op));
        check("Stall_MD",  e.cyc, 32'(Stall_MD),  32'(e.stall));
        check("md_state",  e.cyc, 32'(md_state),  32'(e.state));
        check("stall_cnt", e.cyc, stall_cnt,      e.cnt);
        check("proto_err", e.cyc, 32'(proto_err), 32'(e.err));
      end
    end
  end

  initial begin
    Reset = 1'b1; MDop_E = 3'd0; Kill_E = 1'b0; MDuse_D = 1'b0; busy = 1'b0;

    // 1: mult with a dependent D-stage user: 6 stall cycles
    //    chk rst op kill use busy | op stall st cnt err
    cyc(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    cyc(1, 0, 3, 0, 1, 0,   3, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 1, 2, 0);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 1, 3, 0);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 1, 4, 0);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 1, 5, 0);
    cyc(1, 0, 0, 0, 1, 0,   0, 0, 0, 6, 0);

    // 2: div with no user: 10 wait cycles, no stalls
    cyc(1, 1, 0, 0, 0, 0,   0, 0, 0, 6, 0);
    cyc(1, 0, 5, 0, 0, 0,   5, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    // 3: killed mult is not issued
    cyc(1, 0, 3, 1, 1, 0,   0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);

    // 4: mthi / mtlo pass through without issuing or stalling
    cyc(1, 0, 1, 0, 1, 0,   1, 0, 0, 0, 0);
    cyc(1, 0, 2, 0, 1, 0,   2, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    // 5: busy drops on 3rd wait cycle: sticky error until Reset
    cyc(1, 0, 3, 0, 0, 0,   3, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 1, 0, 1);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 2, 1);
    cyc(1, 1, 0, 0, 0, 0,   0, 0, 0, 2, 1);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    // 6: Reset during div abandons the shadow; multu afterwards is normal
    cyc(1, 0, 5, 0, 0, 0,   5, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0);
    cyc(1, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0);
    cyc(1, 0, 0, 0, 0, 1,   0, 0, 2, 0, 0);
    cyc(1, 1, 0, 0, 0, 1,   0, 0, 2, 0, 0);
    cyc(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
    cyc(1, 0, 4, 0, 1, 0,   4, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);

    // 7: back-to-back issue is flagged and ignored by the shadow
    cyc(1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    cyc(1, 0, 3, 0, 0, 0,   3, 0, 0, 0, 0);
    cyc(1, 0, 5, 0, 0, 1,   5, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 1);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);

    // 7b: busy high while idle with no preceding final wait cycle
    cyc(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);

    // 8: busy lingering one cycle past the wait state is legal and still stalls
    cyc(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    cyc(1, 0, 3, 0, 0, 0,   3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 1,   0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() != 0) @(negedge Clk);
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
